// File: rtl/frame_sequencer.sv
// Frame-control sequencer: derives a frame tick from an internal period timer
// or an external vsync edge, issues the buffer swap/clear/matrix-start pulses,
// holds vertex fetch in reset until the new framebuffer is ready, and keeps
// per-frame pixel, completed-frame and dropped-frame statistics.
module frame_sequencer #(
  parameter int unsigned PERIOD_CYCLES = 2000000,
  parameter int unsigned TIMER_W       = 22,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               enable_in,
  input  logic               mode_in,
  input  logic               vsync_in,
  input  logic               fb_ready_in,
  input  logic               pixel_valid_in,
  output logic               fb_switch_out,
  output logic               fb_clear_out,
  output logic               matrix_start_out,
  output logic               fetch_rst_out,
  output logic               busy_out,
  output logic [COUNT_W-1:0] pixel_count_out,
  output logic [COUNT_W-1:0] frame_count_out,
  output logic [COUNT_W-1:0] drop_count_out
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(PERIOD_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT_READY,
    S_RENDER
  } state_e;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                vsync_q, vsync_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [COUNT_W-1:0]  acc_q, acc_d;
  logic [COUNT_W-1:0]  pixel_count_q, pixel_count_d;
  logic [COUNT_W-1:0]  frame_count_q, frame_count_d;
  logic [COUNT_W-1:0]  drop_count_q, drop_count_d;
  logic                switch_q, switch_d;
  logic                clear_q, clear_d;
  logic                mstart_q, mstart_d;
  logic                fetch_rst_q, fetch_rst_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic [COUNT_W-1:0]  acc_inc;

  // Frame tick source: period timer in mode 0, vsync rising edge in mode 1
  always_comb begin
    timer_d = '0;
    tick    = 1'b0;
    vsync_d = vsync_in;
    if (!mode_in) begin
      tick = (timer_q == TIMER_LAST);
      if (!tick) begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end else begin
      tick = vsync_in & ~vsync_q;
    end
  end

  // State register plus all other sequential state
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      vsync_q       <= 1'b0;
      settle_q      <= '0;
      acc_q         <= '0;
      pixel_count_q <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      switch_q      <= 1'b0;
      clear_q       <= 1'b0;
      mstart_q      <= 1'b0;
      fetch_rst_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      vsync_q       <= vsync_d;
      settle_q      <= settle_d;
      acc_q         <= acc_d;
      pixel_count_q <= pixel_count_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      switch_q      <= switch_d;
      clear_q       <= clear_d;
      mstart_q      <= mstart_d;
      fetch_rst_q   <= fetch_rst_d;
      busy_q        <= busy_d;
    end
  end

  // Next state: a tick pre-empts every other transition
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (tick) begin
      if (enable_in) begin
        state_d  = S_SETTLE;
        settle_d = SETTLE_LOAD;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_SETTLE: begin
          settle_d = settle_q - SETTLE_W'(1);
          if (settle_q <= SETTLE_W'(1)) begin
            state_d = S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (fb_ready_in) begin
            state_d = S_RENDER;
          end
        end
        default: ;
      endcase
    end
  end

  // Statistics: pixel accumulation in RENDER, frame/drop accounting on ticks
  always_comb begin
    acc_inc       = (pixel_valid_in && (acc_q != '1)) ? acc_q + COUNT_W'(1) : acc_q;
    acc_d         = acc_q;
    pixel_count_d = pixel_count_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    if (tick) begin
      acc_d = '0;
      if (enable_in) begin
        case (state_q)
          S_RENDER: begin
            pixel_count_d = acc_inc;
            frame_count_d = frame_count_q + COUNT_W'(1);
          end
          S_SETTLE, S_WAIT_READY: begin
            if (drop_count_q != '1) begin
              drop_count_d = drop_count_q + COUNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end else if (state_q == S_RENDER) begin
      acc_d = acc_inc;
    end
  end

  // Registered outputs derived from the upcoming state and the tick
  always_comb begin
    switch_d    = tick & enable_in;
    clear_d     = tick & enable_in;
    mstart_d    = tick & enable_in;
    fetch_rst_d = (state_d != S_RENDER);
    busy_d      = (state_d == S_RENDER);
  end

  assign fb_switch_out    = switch_q;
  assign fb_clear_out     = clear_q;
  assign matrix_start_out = mstart_q;
  assign fetch_rst_out    = fetch_rst_q;
  assign busy_out         = busy_q;
  assign pixel_count_out  = pixel_count_q;
  assign frame_count_out  = frame_count_q;
  assign drop_count_out   = drop_count_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with PERIOD_CYCLES=20, SETTLE_CYCLES=4.
// Cycle n is the interval after the n-th rising edge following reset release.
module tb_frame_sequencer;

  localparam int unsigned COUNT_W = 16;

  logic               clk_in;
  logic               rst_n_in;
  logic               enable_in;
  logic               mode_in;
  logic               vsync_in;
  logic               fb_ready_in;
  logic               pixel_valid_in;
  logic               fb_switch_out;
  logic               fb_clear_out;
  logic               matrix_start_out;
  logic               fetch_rst_out;
  logic               busy_out;
  logic [COUNT_W-1:0] pixel_count_out;
  logic [COUNT_W-1:0] frame_count_out;
  logic [COUNT_W-1:0] drop_count_out;

  int unsigned checks;
  int unsigned failures;
  int unsigned cur;
  int unsigned sw_cnt;

  frame_sequencer #(
    .PERIOD_CYCLES (20),
    .TIMER_W       (5),
    .SETTLE_CYCLES (4),
    .COUNT_W       (COUNT_W)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .enable_in        (enable_in),
    .mode_in          (mode_in),
    .vsync_in         (vsync_in),
    .fb_ready_in      (fb_ready_in),
    .pixel_valid_in   (pixel_valid_in),
    .fb_switch_out    (fb_switch_out),
    .fb_clear_out     (fb_clear_out),
    .matrix_start_out (matrix_start_out),
    .fetch_rst_out    (fetch_rst_out),
    .busy_out         (busy_out),
    .pixel_count_out  (pixel_count_out),
    .frame_count_out  (frame_count_out),
    .drop_count_out   (drop_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cur, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge clk_in);
    #1;
    cur++;
    if (fb_switch_out) sw_cnt++;
  endtask

  task automatic go_to(input int unsigned c);
    while (cur < c) step();
  endtask

  task automatic check_pulses(input string tag, input logic exp);
    check({tag, "_switch"}, {31'd0, fb_switch_out}, {31'd0, exp});
    check({tag, "_clear"}, {31'd0, fb_clear_out}, {31'd0, exp});
    check({tag, "_mstart"}, {31'd0, matrix_start_out}, {31'd0, exp});
  endtask

  task automatic check_reset_values(input string tag);
    check_pulses(tag, 1'b0);
    check({tag, "_fetch_rst"}, {31'd0, fetch_rst_out}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    check({tag, "_pix"}, {16'd0, pixel_count_out}, 32'd0);
    check({tag, "_frames"}, {16'd0, frame_count_out}, 32'd0);
    check({tag, "_drops"}, {16'd0, drop_count_out}, 32'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cur            = 0;
    sw_cnt         = 0;
    rst_n_in       = 1'b0;
    enable_in      = 1'b1;
    mode_in        = 1'b0;
    vsync_in       = 1'b0;
    fb_ready_in    = 1'b1;
    pixel_valid_in = 1'b0;

    #12;
    check_reset_values("rst");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    cur = 0;

    // First frame: tick at cycle 19, pulses at 20, render from 25
    go_to(19);
    check("pre_tick_switch", {31'd0, fb_switch_out}, 32'd0);
    go_to(20);
    check_pulses("tick1", 1'b1);
    check("tick1_fetch_rst", {31'd0, fetch_rst_out}, 32'd1);
    go_to(21);
    check("tick1_after_switch", {31'd0, fb_switch_out}, 32'd0);
    go_to(24);
    check("settle_fetch_rst", {31'd0, fetch_rst_out}, 32'd1);
    check("settle_busy", {31'd0, busy_out}, 32'd0);
    go_to(25);
    check("render_fetch_rst", {31'd0, fetch_rst_out}, 32'd0);
    check("render_busy", {31'd0, busy_out}, 32'd1);

    // Seven pixels: cycles 30..35 plus the tick cycle 39
    go_to(30); pixel_valid_in = 1'b1;
    go_to(36); pixel_valid_in = 1'b0;
    go_to(39); pixel_valid_in = 1'b1;
    go_to(40); pixel_valid_in = 1'b0;
    check("frame1_pix", {16'd0, pixel_count_out}, 32'd7);
    check("frame1_frames", {16'd0, frame_count_out}, 32'd1);
    check("frame1_switch", {31'd0, fb_switch_out}, 32'd1);
    check("frame1_busy", {31'd0, busy_out}, 32'd0);
    // A pixel during SETTLE is ignored; two pixels in the next RENDER
    go_to(41); pixel_valid_in = 1'b1;
    go_to(42); pixel_valid_in = 1'b0;
    go_to(45);
    check("render2_busy", {31'd0, busy_out}, 32'd1);
    go_to(50); pixel_valid_in = 1'b1;
    go_to(52); pixel_valid_in = 1'b0;
    go_to(60);
    check("frame2_pix", {16'd0, pixel_count_out}, 32'd2);
    check("frame2_frames", {16'd0, frame_count_out}, 32'd2);

    // Framebuffer never ready: two drops
    fb_ready_in = 1'b0;
    go_to(80);
    check("drop1_drops", {16'd0, drop_count_out}, 32'd1);
    check("drop1_switch", {31'd0, fb_switch_out}, 32'd1);
    check("drop1_clear", {31'd0, fb_clear_out}, 32'd1);
    check("drop1_fetch_rst", {31'd0, fetch_rst_out}, 32'd1);
    go_to(100);
    check("drop2_drops", {16'd0, drop_count_out}, 32'd2);
    check("drop2_frames", {16'd0, frame_count_out}, 32'd2);
    check("drop2_pix", {16'd0, pixel_count_out}, 32'd2);
    check("drop2_fetch_rst", {31'd0, fetch_rst_out}, 32'd1);
    // Ready coincident with a tick in WAIT_READY still counts as a drop
    go_to(119); fb_ready_in = 1'b1;
    go_to(120);
    check("coinc_drops", {16'd0, drop_count_out}, 32'd3);
    check("coinc_busy", {31'd0, busy_out}, 32'd0);
    check("coinc_switch", {31'd0, fb_switch_out}, 32'd1);
    go_to(124);
    check("coinc_wait_busy", {31'd0, busy_out}, 32'd0);
    go_to(125);
    check("coinc_render_busy", {31'd0, busy_out}, 32'd1);

    // Vsync mode: no timer ticks, one tick per rising edge
    mode_in = 1'b1;
    sw_cnt = 0;
    go_to(150);
    check("vs_quiet_pulses", sw_cnt, 32'd0);
    check("vs_quiet_busy", {31'd0, busy_out}, 32'd1);
    sw_cnt = 0;
    go_to(153); vsync_in = 1'b1;
    go_to(154);
    check("vs1_switch", {31'd0, fb_switch_out}, 32'd1);
    check("vs1_frames", {16'd0, frame_count_out}, 32'd3);
    check("vs1_pix", {16'd0, pixel_count_out}, 32'd0);
    go_to(156); vsync_in = 1'b0;
    go_to(170);
    check("vs1_pulse_count", sw_cnt, 32'd1);
    vsync_in = 1'b1;
    sw_cnt = 0;
    go_to(173); vsync_in = 1'b0;
    go_to(175);
    check("vs2_pulse_count", sw_cnt, 32'd1);
    check("vs2_frames", {16'd0, frame_count_out}, 32'd4);

    // Back to timer mode (timer restarts from 0 at cycle 175, tick at 194);
    // disable mid-RENDER
    mode_in = 1'b0;
    go_to(180); enable_in = 1'b0;
    go_to(181); pixel_valid_in = 1'b1;
    go_to(184); pixel_valid_in = 1'b0;
    go_to(194);
    check("dis_pre_busy", {31'd0, busy_out}, 32'd1);
    go_to(195);
    check_pulses("dis", 1'b0);
    check("dis_fetch_rst", {31'd0, fetch_rst_out}, 32'd1);
    check("dis_busy", {31'd0, busy_out}, 32'd0);
    check("dis_frames", {16'd0, frame_count_out}, 32'd4);
    check("dis_pix", {16'd0, pixel_count_out}, 32'd0);
    check("dis_drops", {16'd0, drop_count_out}, 32'd3);

    // Re-enable from IDLE: pulses but no drop
    go_to(200); enable_in = 1'b1;
    go_to(215);
    check_pulses("reen", 1'b1);
    check("reen_drops", {16'd0, drop_count_out}, 32'd3);

    // Asynchronous reset in SETTLE, mid-cycle
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_values("arst");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    cur = 0;
    go_to(19);
    check("arst_pre_switch", {31'd0, fb_switch_out}, 32'd0);
    go_to(20);
    check_pulses("arst_tick", 1'b1);
    check("arst_frames", {16'd0, frame_count_out}, 32'd0);
    go_to(25);
    check("arst_render_busy", {31'd0, busy_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
